// File: rtl/uart_frame_controller.sv
// Frame sequencer between the UART receiver and the config register bank.
// Hunts SYNC_BYTE, collects addr/len/payload/checksum, then commits the payload.
module uart_frame_controller #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 41879040
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_frame_done,
    output logic       o_frame_err,
    output logic [2:0] o_err_code,
    output logic [7:0] o_frame_count,
    output logic       o_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CSUM, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovr_q, ovr_d;
    logic          err_pulse_q, err_pulse_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [7:0]    count_q, count_d;
    logic          buf_we;
    logic [7:0]    pbuf_q [MAX_LEN];

    logic in_commit, last_wr, recv;

    assign in_commit = (state_q == COMMIT);
    assign last_wr   = in_commit && (idx_q == 8'(len_q - 8'd1));
    assign recv      = (state_q == ADDR) || (state_q == LEN) ||
                       (state_q == PAYLOAD) || (state_q == CSUM);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        ovr_d       = ovr_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        count_d     = count_q;
        buf_we      = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                ovr_d = 1'b0;
                if (i_byte_valid && (i_byte == SYNC_BYTE)) state_d = ADDR;
            end
            ADDR: begin
                if (i_byte_valid) begin
                    addr_d  = i_byte;
                    csum_d  = i_byte;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (i_byte_valid) begin
                    if ((i_byte == 8'd0) || (i_byte > 8'(MAX_LEN))) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = IDLE;
                    end else begin
                        len_d   = i_byte;
                        csum_d  = csum_q + i_byte;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_byte_valid) begin
                    buf_we = 1'b1;
                    csum_d = csum_q + i_byte;
                    idx_d  = 8'(idx_q + 8'd1);
                    if (idx_q == 8'(len_q - 8'd1)) state_d = CSUM;
                end
            end
            CSUM: begin
                if (i_byte_valid) begin
                    if (i_byte == csum_q) begin
                        idx_d   = '0;
                        ovr_d   = 1'b0;
                        state_d = COMMIT;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = IDLE;
                    end
                end
            end
            COMMIT: begin
                idx_d = 8'(idx_q + 8'd1);
                // A byte in the final write cycle can no longer alter that cycle's pulse; it is dropped silently.
                if (i_byte_valid && !last_wr) ovr_d = 1'b1;
                if (last_wr) begin
                    idx_d   = '0;
                    state_d = IDLE;
                    if (ovr_q) err_code_d = ERR_OVERRUN;
                    else       count_d    = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An arriving byte always beats expiry: expiry only checked on silent cycles.
        if (recv && !i_byte_valid) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
                state_d     = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            ovr_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) pbuf_q[idx_q[IW-1:0]] <= i_byte;
    end

    assign o_wr_en       = in_commit;
    assign o_wr_addr     = in_commit ? 8'(addr_q + idx_q) : '0;
    assign o_wr_data     = in_commit ? pbuf_q[idx_q[IW-1:0]] : '0;
    assign o_frame_done  = last_wr && !ovr_q;
    assign o_frame_err   = err_pulse_q || (last_wr && ovr_q);
    assign o_err_code    = (last_wr && ovr_q) ? ERR_OVERRUN : err_code_q;
    assign o_frame_count = count_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_controller.sv
// Bench for uart_frame_controller: frame-level reference model compared every cycle,
// plus literal expectations for the directed frames.
module tb_uart_frame_controller;

    localparam int         TC   = 20;
    localparam int         ML   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       r_reset;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_frame_done;
    logic       o_frame_err;
    logic [2:0] o_err_code;
    logic [7:0] o_frame_count;
    logic       o_busy;

    uart_frame_controller #(
        .SYNC_BYTE(SYNC),
        .MAX_LEN(ML),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .r_reset(r_reset),
        .i_byte(i_byte),
        .i_byte_valid(i_byte_valid),
        .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done),
        .o_frame_err(o_frame_err),
        .o_err_code(o_err_code),
        .o_frame_count(o_frame_count),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;

    bit         mvalid = 0;
    bit         in_frame;
    bit         ovr;
    int         idle;
    logic [7:0] fq[$];
    wr_t        pend[$];
    logic       e_wr, e_done, e_err, e_busy;
    logic [7:0] e_addr, e_data, e_cnt;
    logic [2:0] e_code;

    task automatic show_head();
        e_wr   = 1'b1;
        e_addr = pend[0].a;
        e_data = pend[0].d;
        if (pend.size() == 1) begin
            e_done = !ovr;
            e_err  = ovr;
            if (ovr) e_code = 3'd4;
        end
    endtask

    task automatic frame_error(input logic [2:0] code);
        e_err    = 1'b1;
        e_code   = code;
        in_frame = 0;
    endtask

    always @(posedge clk) begin
        int n;
        logic [7:0] s;
        e_wr = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
        if (r_reset) begin
            mvalid = 1; in_frame = 0; ovr = 0; idle = 0;
            fq.delete(); pend.delete();
            e_code = 0; e_cnt = 0;
        end else if (pend.size() > 0) begin
            if (i_byte_valid && pend.size() > 1) ovr = 1;
            void'(pend.pop_front());
            if (pend.size() > 0) show_head();
            else begin
                if (!ovr) e_cnt = e_cnt + 8'd1;
                ovr = 0;
            end
        end else if (!in_frame) begin
            if (i_byte_valid && i_byte == SYNC) begin
                in_frame = 1; idle = 0; fq.delete();
            end
        end else if (i_byte_valid) begin
            idle = 0;
            fq.push_back(i_byte);
            n = fq.size();
            if (n == 2 && (fq[1] == 0 || fq[1] > ML)) frame_error(3'd1);
            else if (n >= 3 && n == int'(fq[1]) + 3) begin
                s = 0;
                for (int k = 0; k < n - 1; k++) s = s + fq[k];
                if (s == i_byte) begin
                    for (int i = 0; i < int'(fq[1]); i++) pend.push_back('{8'(fq[0] + i), fq[2 + i]});
                    in_frame = 0; ovr = 0;
                    show_head();
                end else frame_error(3'd2);
            end
        end else begin
            idle++;
            if (idle == TC) frame_error(3'd3);
        end
        e_busy = in_frame || (pend.size() > 0);
    end

    // ---------------- per-cycle compare + write log ----------------
    typedef struct { logic [7:0] a; logic [7:0] d; logic done; } ent_t;
    ent_t wlog[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;

    always @(negedge clk) begin
        if (mvalid) begin
            check("wr_en",   o_wr_en,       e_wr);
            check("wr_addr", o_wr_addr,     e_addr);
            check("wr_data", o_wr_data,     e_data);
            check("done",    o_frame_done,  e_done);
            check("err",     o_frame_err,   e_err);
            check("code",    o_err_code,    e_code);
            check("count",   o_frame_count, e_cnt);
            check("busy",    o_busy,        e_busy);
            if (o_wr_en === 1'b1) wlog.push_back('{o_wr_addr, o_wr_data, o_frame_done});
            if (o_frame_done === 1'b1) done_cnt++;
            if (o_frame_err === 1'b1) err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        i_byte = b;
        i_byte_valid = 1'b1;
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
        i_byte = 8'h00;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [7:0] fr[$];
        int d0, e0;
        r_reset = 1'b1; i_byte = 8'h00; i_byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 r_reset = 1'b0;
        check("rst_wr_en", o_wr_en, 0);
        check("rst_count", o_frame_count, 0);
        check("rst_code",  o_err_code, 0);
        check("rst_busy",  o_busy, 0);

        // good frame
        wlog.delete(); d0 = done_cnt;
        fr = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        send_q(fr); wait_cycles(5);
        check("good_nwr", wlog.size(), 3);
        check("good_w0", {wlog[0].a, wlog[0].d}, 16'h1011);
        check("good_w1", {wlog[1].a, wlog[1].d}, 16'h1122);
        check("good_w2", {wlog[2].a, wlog[2].d}, 16'h1233);
        check("good_done_last", wlog[2].done, 1);
        check("good_done_cnt", done_cnt - d0, 1);
        check("good_count", o_frame_count, 1);
        check("good_code", o_err_code, 0);

        // address wrap with maximum length
        wlog.delete();
        fr = {8'hA5, 8'hFE, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h86);
        send_q(fr); wait_cycles(18);
        check("wrap_nwr", wlog.size(), 16);
        check("wrap_a0", wlog[0].a, 8'hFE);
        check("wrap_a1", wlog[1].a, 8'hFF);
        check("wrap_a2", wlog[2].a, 8'h00);
        check("wrap_last", {wlog[15].a, wlog[15].d}, 16'h0D0F);
        check("wrap_count", o_frame_count, 2);

        // bad checksum, bad lengths
        wlog.delete(); e0 = err_cnt;
        fr = {8'hA5, 8'h20, 8'h01, 8'h55, 8'h00};
        send_q(fr); wait_cycles(3);
        check("csum_nwr", wlog.size(), 0);
        check("csum_code", o_err_code, 2);
        fr = {8'hA5, 8'h20, 8'h00};
        send_q(fr); wait_cycles(3);
        check("len0_code", o_err_code, 1);
        fr = {8'hA5, 8'h20, 8'h02};
        send_q(fr);
        fr = {8'h01, 8'h02, 8'h33};
        send_q(fr); wait_cycles(2);
        check("csum2_code", o_err_code, 2);
        fr = {8'hA5, 8'h20, 8'h17};
        send_q(fr); wait_cycles(3);
        check("len17_code", o_err_code, 1);
        check("bad_errs", err_cnt - e0, 4);

        // timeout, then a byte exactly on the expiry cycle
        e0 = err_cnt;
        fr = {8'hA5, 8'h40};
        send_q(fr); wait_cycles(TC + 3);
        check("tmo_code", o_err_code, 3);
        check("tmo_busy", o_busy, 0);
        check("tmo_errs", err_cnt - e0, 1);
        wlog.delete(); e0 = err_cnt;
        send_q(fr); wait_cycles(TC - 1);
        fr = {8'h01, 8'h07, 8'h48};
        send_q(fr); wait_cycles(3);
        check("alive_errs", err_cnt - e0, 0);
        check("alive_w0", {wlog[0].a, wlog[0].d}, 16'h4007);
        check("alive_count", o_frame_count, 3);
        check("alive_code", o_err_code, 3);

        // overrun during commit
        wlog.delete(); d0 = done_cnt; e0 = err_cnt;
        fr = {8'hA5, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03, 8'h39};
        send_q(fr);
        send(8'hA5);
        wait_cycles(5);
        check("ovr_nwr", wlog.size(), 3);
        check("ovr_code", o_err_code, 4);
        check("ovr_done", done_cnt - d0, 0);
        check("ovr_errs", err_cnt - e0, 1);
        check("ovr_count", o_frame_count, 3);

        // reset on the second write cycle
        wlog.delete();
        fr = {8'hA5, 8'h50, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h84};
        send_q(fr);
        wait_cycles(1);
        r_reset = 1'b1;
        wait_cycles(1);
        r_reset = 1'b0;
        check("rst2_wr_en", o_wr_en, 0);
        check("rst2_addr",  o_wr_addr, 0);
        check("rst2_count", o_frame_count, 0);
        check("rst2_code",  o_err_code, 0);
        check("rst2_busy",  o_busy, 0);
        wait_cycles(3);
        check("rst2_nwr", wlog.size(), 2);

        // good frame after reset
        fr = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        send_q(fr); wait_cycles(4);
        check("post_count", o_frame_count, 1);

        // noise in IDLE, then payload containing the sync value
        e0 = err_cnt;
        fr = {8'h00, 8'hFF, 8'h3C};
        send_q(fr); wait_cycles(2);
        check("noise_errs", err_cnt - e0, 0);
        check("noise_busy", o_busy, 0);
        wlog.delete();
        fr = {8'hA5, 8'h60, 8'h02, 8'hA5, 8'hA5, 8'hAC};
        send_q(fr); wait_cycles(4);
        check("sync_nwr", wlog.size(), 2);
        check("sync_w0", {wlog[0].a, wlog[0].d}, 16'h60A5);
        check("sync_w1", {wlog[1].a, wlog[1].d}, 16'h61A5);
        check("sync_count", o_frame_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
